// File: rtl/aes_defs.sv
// Shared AES definitions used by the SubBytes datapath.
//   - state/byte geometry constants
//   - FSM state encoding for the iterative SubBytes unit
//   - sbox select encoding (forward / inverse)
//   - small elaboration helpers for the lane count
package aes_defs;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = 16;
    localparam int AES_IDX_W   = 4;   // bits needed to address one of 16 bytes

    // State viewed as 16 bytes; element k is in_state[8k+7:8k].
    typedef logic [AES_NBYTES-1:0][AES_BYTE_W-1:0] aes_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fsm_state_e;

    localparam logic SBOX_SEL_FWD = 1'b0;
    localparam logic SBOX_SEL_INV = 1'b1;

    // Counter width, never below one bit so a single-pass build still has a
    // well-formed (constant zero) counter.
    function automatic int cnt_width(input int passes);
        return (passes > 1) ? $clog2(passes) : 1;
    endfunction

    function automatic bit lanes_legal(input int lanes);
        return (lanes == 1) || (lanes == 2) || (lanes == 4) ||
               (lanes == 8) || (lanes == 16);
    endfunction

endpackage

// File: rtl/sbox.sv
// AES byte substitution, forward and inverse, purely combinational.
// Ports:
//   din  [7:0]  byte to substitute
//   sel         SBOX_SEL_FWD -> forward S-box, SBOX_SEL_INV -> inverse S-box
//   dout [7:0]  substituted byte
module sbox
    import aes_defs::*;
(
    input  logic [AES_BYTE_W-1:0] din,
    input  logic                  sel,
    output logic [AES_BYTE_W-1:0] dout
);

    // Element 0 is the leftmost byte of the first row.
    localparam logic [0:255][7:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:255][7:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign dout = (sel == SBOX_SEL_INV) ? INV_TABLE[din] : FWD_TABLE[din];

endmodule

// File: rtl/sub_bytes_iter.sv
// Time-multiplexed AES SubBytes unit. LANES sbox instances substitute LANES
// bytes per cycle, so one 128-bit state takes 16/LANES cycles. Valid/ready
// handshakes on both sides; a finished result can be handed off in the same
// cycle a new state is accepted.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake; in_state/in_sel sampled on accept
//   in_state [127:0]    state to substitute, byte k = in_state[8k+7:8k]
//   in_sel              sbox direction (forward / inverse)
//   out_valid/out_ready output handshake
//   out_state [127:0]   substituted state (intermediate while out_valid=0)
module sub_bytes_iter
    import aes_defs::*;
#(
    parameter int LANES = 4
)
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int PASSES = AES_NBYTES / LANES;
    localparam int CNT_W  = cnt_width(PASSES);
    localparam logic [CNT_W-1:0] LAST_PASS = CNT_W'(PASSES - 1);

    generate
        if (!lanes_legal(LANES)) begin : g_bad_lanes
            $error("sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    fsm_state_e       fsm_reg, fsm_next;
    aes_state_t       data_reg, data_next;
    logic             sel_reg, sel_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic [AES_IDX_W-1:0]  lane_idx [LANES];
    logic [AES_BYTE_W-1:0] lane_in  [LANES];
    logic [AES_BYTE_W-1:0] lane_out [LANES];

    // Lane gi works on byte cnt*LANES+gi of the held state. With 16 lanes
    // there is only one pass, so the byte select is fixed wiring.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            if (LANES == AES_NBYTES) begin : g_direct
                assign lane_idx[gi] = AES_IDX_W'(gi);
            end else begin : g_mux
                assign lane_idx[gi] = AES_IDX_W'(int'(cnt_reg) * LANES + gi);
            end

            assign lane_in[gi] = data_reg[lane_idx[gi]];

            sbox u_sbox (
                .din  (lane_in[gi]),
                .sel  (sel_reg),
                .dout (lane_out[gi])
            );
        end
    endgenerate

    always_comb begin
        fsm_next  = fsm_reg;
        data_next = data_reg;
        sel_next  = sel_reg;
        cnt_next  = cnt_reg;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (fsm_reg)
            ST_IDLE: begin
                in_ready = 1'b1;
            end
            ST_BUSY: begin
                // Substituted bytes are written back in place; the rest hold.
                for (int i = 0; i < LANES; i++) begin
                    data_next[lane_idx[i]] = lane_out[i];
                end
                if (cnt_reg == LAST_PASS) begin
                    cnt_next = '0;
                    fsm_next = ST_DONE;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // Ready to take a new state exactly when the current result leaves.
                in_ready  = out_ready;
                if (out_ready) begin
                    fsm_next = ST_IDLE;
                end
            end
            default: begin
                fsm_next = ST_IDLE;
            end
        endcase

        // Accept overrides the DONE->IDLE hand-off so back-to-back states
        // go straight to BUSY without an idle bubble.
        if (in_ready && in_valid) begin
            data_next = in_state;
            sel_next  = in_sel;
            cnt_next  = '0;
            fsm_next  = ST_BUSY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg  <= ST_IDLE;
            data_reg <= '0;
            sel_reg  <= SBOX_SEL_FWD;
            cnt_reg  <= '0;
        end else begin
            fsm_reg  <= fsm_next;
            data_reg <= data_next;
            sel_reg  <= sel_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign out_state = data_reg;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Testbench for sub_bytes_iter: one instance per legal LANES value
// (instance k has LANES = 1<<k). Reference S-box built from GF(2^8)
// inversion plus the AES affine map.
module tb_sub_bytes_iter;

    localparam int NI = 5;
    localparam logic [127:0] FIPS_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_OUT = 128'h638293c31bfc33f5c4eeacea4bc12816;

    logic clk = 1'b0;
    logic rst;
    logic         iv   [NI];
    logic         ir   [NI];
    logic         isel [NI];
    logic         ov   [NI];
    logic         ordy [NI];
    logic [127:0] ist  [NI];
    logic [127:0] ost  [NI];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        sub_bytes_iter #(.LANES(1 << gi)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[gi]),
            .in_ready  (ir[gi]),
            .in_state  (ist[gi]),
            .in_sel    (isel[gi]),
            .out_valid (ov[gi]),
            .out_ready (ordy[gi]),
            .out_state (ost[gi])
        );
    end

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0] ref_fwd [256];
    logic [7:0] ref_inv [256];

    typedef struct {
        int           k;
        logic         sel;
        logic [127:0] din;
        logic [127:0] dexp;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] w = {b, b};
        w = w >> (8 - n);
        return w[7:0];
    endfunction

    task automatic build_model();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] s;
            if (b != 0) begin
                for (int x = 1; x < 256; x++) begin
                    if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
                end
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_fwd[b] = s;
            ref_inv[s] = 8'(b);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic sel);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[i*8 +: 8] = sel ? ref_inv[d[i*8 +: 8]] : ref_fwd[d[i*8 +: 8]];
        end
        return r;
    endfunction

    // ---------------- one full transaction on instance k ----------------
    task automatic xfer(input int k, input logic [127:0] d, input logic s,
                        output logic [127:0] res, output int lat);
        @(negedge clk);
        ist[k] = d; isel[k] = s; iv[k] = 1'b1; ordy[k] = 1'b1;
        #1 chk1("in_ready_idle", ir[k], 1'b1);
        @(posedge clk);
        #1 iv[k] = 1'b0;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!ov[k] && lat < 40);
        res = ost[k];
        @(posedge clk); #1;
        chk1("idle_after_handoff", ov[k], 1'b0);
        $display("xfer lanes=%0d sel=%0d in=%h out=%h lat=%0d", 1 << k, s, d, res, lat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [127:0] res, res2, d;
        int lat, cyc;
        logic seen;

        build_model();
        tbl[0] = '{2, 1'b0, FIPS_IN, FIPS_OUT};
        tbl[1] = '{0, 1'b1, FIPS_OUT, FIPS_IN};
        tbl[2] = '{1, 1'b0, 128'h0, {16{8'h63}}};
        tbl[3] = '{3, 1'b0, {16{8'h53}}, {16{8'hed}}};
        tbl[4] = '{4, 1'b0, FIPS_IN, FIPS_OUT};
        tbl[5] = '{4, 1'b1, FIPS_OUT, FIPS_IN};
        tbl[6] = '{3, 1'b1, {16{8'h63}}, 128'h0};
        tbl[7] = '{0, 1'b0, FIPS_IN, FIPS_OUT};

        for (int k = 0; k < NI; k++) begin
            iv[k] = 1'b0; isel[k] = 1'b0; ordy[k] = 1'b1; ist[k] = '0;
        end
        rst = 1'b1;
        #12;
        for (int k = 0; k < NI; k++) begin
            chk1("reset_out_valid", ov[k], 1'b0);
            chk1("reset_in_ready", ir[k], 1'b1);
            chk("reset_out_state", ost[k], 128'h0);
        end
        @(negedge clk) rst = 1'b0;

        // ---- table-driven known-answer vectors ----
        for (int v = 0; v < 8; v++) begin
            xfer(tbl[v].k, tbl[v].din, tbl[v].sel, res, lat);
            chk("table_result", res, tbl[v].dexp);
            chk_int("table_latency", lat, 16 >> tbl[v].k);
        end

        // ---- LANES=4: inputs glitching while busy, in_ready low, out_valid timing ----
        @(negedge clk);
        ist[2] = FIPS_IN; isel[2] = 1'b0; iv[2] = 1'b1; ordy[2] = 1'b0;
        @(posedge clk);
        for (cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            ist[2] = {$urandom, $urandom, $urandom, $urandom};
            isel[2] = ~isel[2];
            @(posedge clk); #1;
            chk1("glitch_in_ready_low", ir[2], 1'b0);
            chk1("glitch_out_valid", ov[2], (cyc == 4));
        end
        chk("glitch_result", ost[2], FIPS_OUT);
        @(negedge clk) iv[2] = 1'b0; ordy[2] = 1'b1;
        @(posedge clk); #1;
        chk1("glitch_handoff", ov[2], 1'b0);
        $display("glitch lanes=4 out=%h", FIPS_OUT);

        // ---- LANES=2: backpressure then back-to-back accept ----
        @(negedge clk);
        ist[1] = FIPS_IN; isel[1] = 1'b0; iv[1] = 1'b1; ordy[1] = 1'b0;
        @(posedge clk); #1 iv[1] = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ov[1] && lat < 40);
        chk_int("bp_latency", lat, 8);
        for (cyc = 0; cyc < 5; cyc++) begin
            @(posedge clk); #1;
            chk("bp_state_stable", ost[1], FIPS_OUT);
            chk1("bp_out_valid_held", ov[1], 1'b1);
            chk1("bp_in_ready_low", ir[1], 1'b0);
        end
        @(negedge clk);
        ordy[1] = 1'b1; iv[1] = 1'b1; ist[1] = 128'h0; isel[1] = 1'b0;
        #1 chk1("b2b_in_ready", ir[1], 1'b1);
        @(posedge clk); #1 iv[1] = 1'b0;
        chk1("b2b_no_bubble", ov[1], 1'b0);
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ov[1] && lat < 40);
        chk_int("b2b_latency", lat, 8);
        chk("b2b_result", ost[1], {16{8'h63}});
        @(posedge clk); #1;
        $display("backpressure lanes=2 second_out=%h lat=%0d", {16{8'h63}}, lat);

        // ---- LANES=8: asynchronous reset mid-operation ----
        @(negedge clk);
        ist[3] = FIPS_IN; isel[3] = 1'b0; iv[3] = 1'b1; ordy[3] = 1'b1;
        @(posedge clk); #1 iv[3] = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        chk1("rst_mid_out_valid", ov[3], 1'b0);
        chk1("rst_mid_in_ready", ir[3], 1'b1);
        chk("rst_mid_out_state", ost[3], 128'h0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        for (cyc = 0; cyc < 10; cyc++) begin
            @(posedge clk); #1;
            if (ov[3]) seen = 1'b1;
        end
        chk1("rst_no_stale_output", seen, 1'b0);
        xfer(3, {16{8'h53}}, 1'b0, res, lat);
        chk("rst_fresh_result", res, {16{8'hed}});
        chk_int("rst_fresh_latency", lat, 2);

        // ---- random sweep over all lane counts: fwd then inv ----
        for (int k = 0; k < NI; k++) begin
            for (int r = 0; r < 4; r++) begin
                d = {$urandom, $urandom, $urandom, $urandom};
                xfer(k, d, 1'b0, res, lat);
                chk("sweep_fwd", res, model(d, 1'b0));
                chk_int("sweep_fwd_latency", lat, 16 >> k);
                xfer(k, res, 1'b1, res2, lat);
                chk("sweep_roundtrip", res2, d);
                chk_int("sweep_inv_latency", lat, 16 >> k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/sub_bytes_iter.md
Name: sub_bytes_iter

Overview:
Parametrised, time-multiplexed SubBytes unit for the AES pipeline. It applies the forward or inverse S-box to a 128-bit state using LANES sbox instances, processing LANES bytes per cycle over 16/LANES passes. A valid/ready handshake on both sides lets round logic trade area against latency without changing the round controller.

Parameters:
LANES, 4, number of sbox instances and bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
PASSES, 16/LANES, derived localparam; number of cycles per state.
CNT_W, max(1, clog2(PASSES)), derived localparam; pass-counter width.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_state/in_sel valid
in_ready  output  1  unit can accept a state this cycle
in_state  input  128  state; byte k = in_state[8k+7:8k]
in_sel  input  1  sbox select passed to every sbox instance (same encoding as the existing sbox sel: forward/inverse)
out_valid  output  1  out_state holds a completed result
out_ready  input  1  downstream accepts out_state
out_state  output  128  substituted state, same byte order as input

Behaviour:
- Reset (asynchronous, active-high): FSM goes to IDLE; state_q=0, sel_q=0, cnt=0; out_valid=0, in_ready=1, out_state=0. Reset mid-operation discards the state in flight and produces no output.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid is high, load state_q<=in_state, sel_q<=in_sel, cnt<=0, and go to BUSY.
- BUSY: in_ready=0, out_valid=0. Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of state_q are replaced in place by sbox(byte, sel_q); all other bytes hold; cnt increments.
- End of BUSY: on the pass with cnt==PASSES-1, go to DONE and clear cnt to 0.
- Latency: out_valid rises exactly PASSES cycles after the accept edge (LANES=16 gives 1, LANES=4 gives 4, LANES=1 gives 16).
- Throughput: one state per PASSES+1 cycles when back-to-back.
- DONE: out_valid=1; out_state=state_q, held stable until out_ready.
  - in_ready = out_ready, so the unit can accept a new state in the same cycle it hands one off.
  - out_ready=1 with in_valid=1: load the new state and go to BUSY (no bubble through IDLE).
  - out_ready=1 with in_valid=0: go to IDLE.
  - out_ready=0: hold DONE indefinitely; out_state unchanged.
- in_sel and in_state are sampled only on the accept edge. Changes while BUSY or DONE have no effect.
- out_state always reflects state_q. Intermediate values are visible while out_valid=0 and are don't-care to consumers.
- Sbox is combinational; there is no extra pipeline stage inside a pass.
- Lane mux: lane i reads byte cnt*LANES+i. Select widths are CNT_W bits. For LANES=16 the counter is unused (always 0) and the mux reduces to direct wiring.

Decomposition:
- Shared package/header `aes_defs`:
  - AES_STATE_W=128, AES_BYTE_W=8, AES_NBYTES=16;
  - FSM state encodings (IDLE, BUSY, DONE);
  - sbox sel encodings for forward and inverse.
- Sub-modules:
  - Reuse the existing `sbox` (8-bit in/out plus sel), instantiated LANES times in a generate loop.
  - No new sub-module; the byte-select/write-back mux stays inline.

Test Plan:
- Forward, LANES=4: in_state=00112233445566778899aabbccddeeff (FIPS-197 byte order), fwd sel, accepted at edge T -> out_valid first high at edge T+4; out_state=638293c31bfc33f5c4eeacea4bc12816; in_ready=0 at edges T+1..T+4.
- Inverse round-trip, LANES=1: feed 638293c31bfc33f5c4eeacea4bc12816 with inverse sel -> out_state=00112233445566778899aabbccddeeff after exactly 16 cycles.
- Backpressure plus back-to-back, LANES=2:
  - hold out_ready=0 for 5 cycles after out_valid -> out_state stable, in_ready=0;
  - then out_ready=1 with in_valid=1 carrying all-zero, fwd -> new state accepted the same edge, next result all-0x63 after 8 cycles.
- sel/input glitch, LANES=4: toggle in_sel and change in_state every cycle while BUSY -> result matches the values sampled at acceptance.
- Reset mid-op, LANES=8: assert rst asynchronously one cycle after accept (between edges) -> out_valid=0, in_ready=1, out_state=0 immediately; after release, no stale result is emitted and a fresh all-0x53 input yields all-0xED.
- Parameter sweep LANES in {1,2,4,8,16}: random states, fwd then inv -> identity, and latency equals 16/LANES in every case.
